// File: rtl/rover_path_planner.sv
// ---------------------------------------------------------------------------
// rover_path_planner
//
// Sequences a rover toward a target location. Each pass makes a short probe
// move to learn the current heading, then asks an external math helper for
// the heading/distance to the target and issues a path move. After each path
// move the remaining distance is rechecked. The run ends with reached_target
// (inside ARRIVE_TOL), or missed_target (attempt budget spent or a wait timed
// out). Locations are packed as {theta, r}.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   start                 begin a run (taken in IDLE only)
//   abort                 cancel the run, return to IDLE, flags untouched
//   enable                one-cycle strobe: rover_location is fresh
//   rover_location        latest rover position {theta, r}
//   target_location       destination {theta, r}
//   math_start/math_mode  helper request pulse; mode 0 orientation, 1 path
//   math_a/math_b         helper operands, held until the helper answers
//   math_done             helper result strobe
//   math_orientation      helper heading/turn result
//   math_distance         helper distance result
//   move_command          {turn, distance} for the drive system
//   move_ready            one-cycle pulse, move_command valid
//   orientation           latest measured heading
//   orientation_done      heading valid for this run
//   reached_target        run ended within ARRIVE_TOL of the target
//   missed_target         run ended without reaching the target
//   busy                  state != IDLE
//   state                 current state code, for debug
//
// state           | meaning
// ----------------+-----------------------------------------------------------
// IDLE         1  | waiting for start; flags from the last run held
// START_ORIENT 2  | issue the fixed probe move
// WAIT_ORIENT_LOC 3 | wait for the location after the probe move
// CALC_ORIENT  4  | wait for helper heading (origin -> current)
// CALC_PATH    5  | wait for helper path (current -> target)
// ISSUE_MOVE   6  | issue the latched path move, count the attempt
// WAIT_MOVE_LOC 7 | wait for the location after the path move
// CHECK        8  | wait for helper distance, decide reach/miss/re-orient
// DONE         9  | one cycle with final flags, then IDLE
// ---------------------------------------------------------------------------
module rover_path_planner #(
  parameter int R_WIDTH      = 8,
  parameter int THETA_WIDTH  = 4,
  parameter int ORIENT_WIDTH = 5,
  parameter int DIST_WIDTH   = 7,
  parameter int ORIENT_STEP  = 5,
  parameter int MAX_ATTEMPTS = 3,
  parameter int ARRIVE_TOL   = 3,
  parameter int LOC_TIMEOUT  = 1000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                enable,
  input  logic [R_WIDTH+THETA_WIDTH-1:0]      rover_location,
  input  logic [R_WIDTH+THETA_WIDTH-1:0]      target_location,
  output logic                                math_start,
  output logic                                math_mode,
  output logic [R_WIDTH+THETA_WIDTH-1:0]      math_a,
  output logic [R_WIDTH+THETA_WIDTH-1:0]      math_b,
  input  logic                                math_done,
  input  logic [ORIENT_WIDTH-1:0]             math_orientation,
  input  logic [DIST_WIDTH-1:0]               math_distance,
  output logic [ORIENT_WIDTH+DIST_WIDTH-1:0]  move_command,
  output logic                                move_ready,
  output logic [ORIENT_WIDTH-1:0]             orientation,
  output logic                                orientation_done,
  output logic                                reached_target,
  output logic                                missed_target,
  output logic                                busy,
  output logic [3:0]                          state
);

  localparam int LOC_W = R_WIDTH + THETA_WIDTH;
  localparam int CMD_W = ORIENT_WIDTH + DIST_WIDTH;
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMO_W = $clog2(LOC_TIMEOUT + 1);

  localparam logic [DIST_WIDTH-1:0] TOL       = DIST_WIDTH'(ARRIVE_TOL);
  localparam logic [ATT_W-1:0]      ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
  localparam logic [TMO_W-1:0]      TMO_LOAD  = TMO_W'(LOC_TIMEOUT - 1);
  localparam logic [CMD_W-1:0]      PROBE_CMD = {{ORIENT_WIDTH{1'b0}}, DIST_WIDTH'(ORIENT_STEP)};

  typedef enum logic [3:0] {
    ST_IDLE            = 4'd1,
    ST_START_ORIENT    = 4'd2,
    ST_WAIT_ORIENT_LOC = 4'd3,
    ST_CALC_ORIENT     = 4'd4,
    ST_CALC_PATH       = 4'd5,
    ST_ISSUE_MOVE      = 4'd6,
    ST_WAIT_MOVE_LOC   = 4'd7,
    ST_CHECK           = 4'd8,
    ST_DONE            = 4'd9
  } state_t;

  state_t state_q, state_next;

  logic [LOC_W-1:0] origin_q;
  logic [LOC_W-1:0] current_q;
  logic [CMD_W-1:0] path_cmd_q;
  logic [ATT_W-1:0] att_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             near;

  logic act_accept;
  logic act_probe;
  logic act_launch_orient;
  logic act_orient_done;
  logic act_path_far;
  logic act_issue;
  logic act_launch_check;
  logic act_reorient;
  logic set_reached;
  logic set_missed;

  assign tmo_hit = (tmo_cnt == '0);
  assign near    = (math_distance <= TOL);
  assign busy    = (state_q != ST_IDLE);
  assign state   = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next        = state_q;
    act_accept        = 1'b0;
    act_probe         = 1'b0;
    act_launch_orient = 1'b0;
    act_orient_done   = 1'b0;
    act_path_far      = 1'b0;
    act_issue         = 1'b0;
    act_launch_check  = 1'b0;
    act_reorient      = 1'b0;
    set_reached       = 1'b0;
    set_missed        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_START_ORIENT;
          act_accept = 1'b1;
        end
      end
      ST_START_ORIENT: begin
        act_probe  = 1'b1;
        state_next = ST_WAIT_ORIENT_LOC;
      end
      ST_WAIT_ORIENT_LOC: begin
        if (enable) begin
          act_launch_orient = 1'b1;
          state_next        = ST_CALC_ORIENT;
        end else if (tmo_hit) begin
          set_missed = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_CALC_ORIENT: begin
        if (math_done) begin
          act_orient_done = 1'b1;
          state_next      = ST_CALC_PATH;
        end else if (tmo_hit) begin
          set_missed = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_CALC_PATH: begin
        if (math_done) begin
          if (near) begin
            set_reached = 1'b1;
            state_next  = ST_DONE;
          end else begin
            act_path_far = 1'b1;
            state_next   = ST_ISSUE_MOVE;
          end
        end else if (tmo_hit) begin
          set_missed = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_ISSUE_MOVE: begin
        act_issue  = 1'b1;
        state_next = ST_WAIT_MOVE_LOC;
      end
      ST_WAIT_MOVE_LOC: begin
        if (enable) begin
          act_launch_check = 1'b1;
          state_next       = ST_CHECK;
        end else if (tmo_hit) begin
          set_missed = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_CHECK: begin
        if (math_done) begin
          if (near) begin
            set_reached = 1'b1;
            state_next  = ST_DONE;
          end else if (att_cnt == ATT_MAX) begin
            set_missed = 1'b1;
            state_next = ST_DONE;
          end else begin
            act_reorient = 1'b1;
            state_next   = ST_START_ORIENT;
          end
        end else if (tmo_hit) begin
          set_missed = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort wins over every strobe; it also blocks a start arriving with it.
    if (abort) begin
      state_next        = ST_IDLE;
      act_accept        = 1'b0;
      act_probe         = 1'b0;
      act_launch_orient = 1'b0;
      act_orient_done   = 1'b0;
      act_path_far      = 1'b0;
      act_issue         = 1'b0;
      act_launch_check  = 1'b0;
      act_reorient      = 1'b0;
      set_reached       = 1'b0;
      set_missed        = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      move_command     <= '0;
      move_ready       <= 1'b0;
      orientation      <= '0;
      orientation_done <= 1'b0;
      reached_target   <= 1'b0;
      missed_target    <= 1'b0;
      math_start       <= 1'b0;
      math_mode        <= 1'b0;
      math_a           <= '0;
      math_b           <= '0;
      origin_q         <= '0;
      current_q        <= '0;
      path_cmd_q       <= '0;
      att_cnt          <= '0;
      tmo_cnt          <= '0;
    end else begin
      move_ready <= 1'b0;
      math_start <= 1'b0;

      // Down-counter reloads on every state change, so each wait state
      // gets exactly LOC_TIMEOUT cycles before tmo_hit forces DONE.
      if (state_next != state_q) begin
        tmo_cnt <= TMO_LOAD;
      end else if (!tmo_hit) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end

      if (act_accept) begin
        orientation_done <= 1'b0;
        reached_target   <= 1'b0;
        missed_target    <= 1'b0;
        att_cnt          <= '0;
      end

      if (act_probe) begin
        // On re-orientation passes origin already holds the last confirmed
        // location from CHECK; only the first pass samples the live input.
        if (att_cnt == '0) begin
          origin_q <= rover_location;
        end
        move_command <= PROBE_CMD;
        move_ready   <= 1'b1;
      end

      if (act_launch_orient) begin
        current_q  <= rover_location;
        math_start <= 1'b1;
        math_mode  <= 1'b0;
        math_a     <= origin_q;
        math_b     <= rover_location;
      end

      if (act_orient_done) begin
        orientation      <= math_orientation;
        orientation_done <= 1'b1;
        math_start       <= 1'b1;
        math_mode        <= 1'b1;
        math_a           <= current_q;
        math_b           <= target_location;
      end

      if (act_path_far) begin
        path_cmd_q <= {math_orientation, math_distance};
      end

      if (act_issue) begin
        move_command <= path_cmd_q;
        move_ready   <= 1'b1;
        att_cnt      <= att_cnt + ATT_W'(1);
      end

      if (act_launch_check) begin
        current_q  <= rover_location;
        math_start <= 1'b1;
        math_mode  <= 1'b1;
        math_a     <= rover_location;
        math_b     <= target_location;
      end

      if (act_reorient) begin
        origin_q <= current_q;
      end

      if (set_reached) begin
        reached_target <= 1'b1;
      end

      if (set_missed) begin
        missed_target <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rover_path_planner.sv
// ---------------------------------------------------------------------------
// tb_rover_path_planner
//
// The bench plays the rover and the math helper. Each mission is modelled as
// a sequence of transactions (probe move, orientation query, path query,
// path move, recheck) derived from the planner's rules; helper answers and
// locations are random, with forced distance scripts for directed cases.
// ---------------------------------------------------------------------------
module tb_rover_path_planner;

  localparam int RW = 8, TW = 4, OW = 5, DW = 7;
  localparam int LW = RW + TW, CW = OW + DW;
  localparam int STEP = 5, MAXA = 3, TOL = 3, TMO = 1000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] rover_location = '0;
  logic [LW-1:0] target_location = '0;
  logic          math_start;
  logic          math_mode;
  logic [LW-1:0] math_a;
  logic [LW-1:0] math_b;
  logic          math_done = 1'b0;
  logic [OW-1:0] math_orientation = '0;
  logic [DW-1:0] math_distance = '0;
  logic [CW-1:0] move_command;
  logic          move_ready;
  logic [OW-1:0] orientation;
  logic          orientation_done;
  logic          reached_target;
  logic          missed_target;
  logic          busy;
  logic [3:0]    state;

  int total = 0;
  int bad = 0;
  int mr_count = 0;
  int dist_q[$];

  rover_path_planner dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .rover_location(rover_location), .target_location(target_location),
    .math_start(math_start), .math_mode(math_mode), .math_a(math_a), .math_b(math_b),
    .math_done(math_done), .math_orientation(math_orientation), .math_distance(math_distance),
    .move_command(move_command), .move_ready(move_ready), .orientation(orientation),
    .orientation_done(orientation_done), .reached_target(reached_target),
    .missed_target(missed_target), .busy(busy), .state(state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (move_ready) mr_count++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int next_dist();
    if (dist_q.size() > 0) return dist_q.pop_front();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 4));
    return int'($urandom_range(4, 127));
  endfunction

  // kind 1: spurious math_done, kind 2: spurious enable; both add spurious start
  task automatic idle_cycles(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if (kind == 1) begin
          math_distance = DW'($urandom);
          math_done = 1'b1;
        end else begin
          enable = 1'b1;
        end
      end
      if ($urandom_range(0, 3) == 0) start = 1'b1;
      tick();
      math_done = 1'b0;
      enable = 1'b0;
      start = 1'b0;
      chk("idle_no_math_start", 32'(math_start), 32'd0);
      chk("idle_no_move_ready", 32'(move_ready), 32'd0);
    end
  endtask

  task automatic give_loc(input logic [LW-1:0] loc);
    rover_location = loc;
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic give_math(input logic [OW-1:0] o, input logic [DW-1:0] d);
    math_orientation = o;
    math_distance = d;
    math_done = 1'b1;
    tick();
    math_done = 1'b0;
  endtask

  task automatic mission(input logic [LW-1:0] start_loc, input logic [LW-1:0] tgt,
                         input logic [LW-1:0] first_loc, input logic [OW-1:0] first_orient);
    logic [LW-1:0] origin, cur;
    logic [OW-1:0] o;
    int d, att, moves, mr0;
    bit exp_reach, exp_miss, fin;
    rover_location = start_loc;
    target_location = tgt;
    mr0 = mr_count;
    moves = 0; att = 0; fin = 0; exp_reach = 0; exp_miss = 0;
    origin = start_loc; cur = first_loc; o = first_orient;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", 32'(state), 32'd2);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_no_ready_yet", 32'(move_ready), 32'd0);
    chk("start_clear_reached", 32'(reached_target), 32'd0);
    chk("start_clear_missed", 32'(missed_target), 32'd0);
    chk("start_clear_odone", 32'(orientation_done), 32'd0);
    tick();
    chk("probe_ready", 32'(move_ready), 32'd1);
    chk("probe_cmd", 32'(move_command), 32'(STEP));
    moves++;

    for (int it = 0; it < MAXA && !fin; it++) begin
      idle_cycles(int'($urandom_range(0, 3)), 1);
      give_loc(cur);
      chk("orient_math_start", 32'(math_start), 32'd1);
      chk("orient_mode", 32'(math_mode), 32'd0);
      chk("orient_a", 32'(math_a), 32'(origin));
      chk("orient_b", 32'(math_b), 32'(cur));
      idle_cycles(int'($urandom_range(0, 3)), 2);
      chk("orient_a_hold", 32'(math_a), 32'(origin));
      give_math(o, DW'($urandom));
      chk("orientation", 32'(orientation), 32'(o));
      chk("orientation_done", 32'(orientation_done), 32'd1);
      chk("path_math_start", 32'(math_start), 32'd1);
      chk("path_mode", 32'(math_mode), 32'd1);
      chk("path_a", 32'(math_a), 32'(cur));
      chk("path_b", 32'(math_b), 32'(tgt));
      idle_cycles(int'($urandom_range(0, 3)), 2);
      d = next_dist();
      give_math(o, DW'(d));
      if (d <= TOL) begin
        exp_reach = 1; fin = 1;
      end else begin
        chk("issue_state", 32'(state), 32'd6);
        tick();
        chk("issue_ready", 32'(move_ready), 32'd1);
        chk("issue_cmd", 32'(move_command), 32'({o, DW'(d)}));
        moves++; att++;
        idle_cycles(int'($urandom_range(0, 3)), 1);
        cur = LW'($urandom);
        give_loc(cur);
        chk("check_math_start", 32'(math_start), 32'd1);
        chk("check_mode", 32'(math_mode), 32'd1);
        chk("check_a", 32'(math_a), 32'(cur));
        chk("check_b", 32'(math_b), 32'(tgt));
        idle_cycles(int'($urandom_range(0, 3)), 2);
        d = next_dist();
        give_math(OW'($urandom), DW'(d));
        if (d <= TOL) begin
          exp_reach = 1; fin = 1;
        end else if (att == MAXA) begin
          exp_miss = 1; fin = 1;
        end else begin
          origin = cur;
          chk("reorient_state", 32'(state), 32'd2);
          chk("reorient_no_ready_yet", 32'(move_ready), 32'd0);
          tick();
          chk("reprobe_ready", 32'(move_ready), 32'd1);
          chk("reprobe_cmd", 32'(move_command), 32'(STEP));
          moves++;
          cur = LW'($urandom);
          o = OW'($urandom);
        end
      end
    end

    chk("end_state_done", 32'(state), 32'd9);
    chk("end_reached", 32'(reached_target), 32'(exp_reach));
    chk("end_missed", 32'(missed_target), 32'(exp_miss));
    tick();
    chk("end_state_idle", 32'(state), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("hold_reached", 32'(reached_target), 32'(exp_reach));
    chk("hold_missed", 32'(missed_target), 32'(exp_miss));
    chk("hold_orientation", 32'(orientation), 32'(o));
    chk("hold_odone", 32'(orientation_done), 32'd1);
    repeat (3) tick();
    chk("move_count", 32'(mr_count - mr0), 32'(moves));
  endtask

  initial begin
    int mr0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_move_ready", 32'(move_ready), 32'd0);
    chk("rst_move_command", 32'(move_command), 32'd0);
    chk("rst_math_start", 32'(math_start), 32'd0);
    chk("rst_flags", 32'({orientation_done, reached_target, missed_target}), 32'd0);
    reset = 1'b0;
    tick();

    // single-shot arrival
    dist_q = '{2};
    mission(12'h0A0, 12'h1F0, 12'h103, 5'h07);
    // one path move then arrival
    dist_q = '{32, 1};
    mission(12'h011, 12'h2C4, 12'h055, 5'h07);
    // never closer: three attempts then miss
    dist_q = '{32, 32, 32, 32, 32, 32};
    mission(12'h300, 12'h0FF, 12'h321, 5'h1A);
    // boundary distances exactly at and just above tolerance
    dist_q = '{TOL + 1, TOL};
    mission(12'h123, 12'h456, 12'h789, 5'h03);

    for (int m = 0; m < 25; m++) begin
      dist_q.delete();
      mission(LW'($urandom), LW'($urandom), LW'($urandom), OW'($urandom));
    end

    // location timeout in WAIT_ORIENT_LOC
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("tmo_enter", 32'(state), 32'd3);
    repeat (TMO - 1) tick();
    chk("tmo_last_wait", 32'(state), 32'd3);
    tick();
    chk("tmo_done", 32'(state), 32'd9);
    chk("tmo_missed", 32'(missed_target), 32'd1);
    chk("tmo_not_reached", 32'(reached_target), 32'd0);
    tick();
    chk("tmo_idle", 32'(state), 32'd1);
    chk("tmo_missed_hold", 32'(missed_target), 32'd1);

    // abort colliding with math_done in CALC_PATH
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; tick(); start = 1'b0;
      tick();
      give_loc(12'h051);
      give_math(5'h03, 7'h00);
      chk("abort_pre_state", 32'(state), 32'd5);
      mr0 = mr_count;
      abort = 1'b1;
      math_orientation = 5'h04;
      math_distance = (k == 0) ? 7'h20 : 7'h01;
      math_done = 1'b1;
      tick();
      abort = 1'b0;
      math_done = 1'b0;
      chk("abort_state", 32'(state), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_math_start", 32'(math_start), 32'd0);
      chk("abort_reached", 32'(reached_target), 32'd0);
      chk("abort_missed", 32'(missed_target), 32'd0);
      repeat (3) tick();
      chk("abort_no_move", 32'(mr_count - mr0), 32'd0);
    end

    // reset in the middle of WAIT_MOVE_LOC
    start = 1'b1; tick(); start = 1'b0;
    tick();
    give_loc(12'h222);
    give_math(5'h09, 7'h00);
    give_math(5'h09, 7'h20);
    tick();
    chk("rst_mid_pre_state", 32'(state), 32'd7);
    reset = 1'b1;
    tick();
    chk("rst_mid_state", 32'(state), 32'd1);
    chk("rst_mid_move_command", 32'(move_command), 32'd0);
    chk("rst_mid_move_ready", 32'(move_ready), 32'd0);
    chk("rst_mid_orientation", 32'(orientation), 32'd0);
    chk("rst_mid_odone", 32'(orientation_done), 32'd0);
    chk("rst_mid_reached", 32'(reached_target), 32'd0);
    chk("rst_mid_missed", 32'(missed_target), 32'd0);
    chk("rst_mid_math_start", 32'(math_start), 32'd0);
    chk("rst_mid_math_mode", 32'(math_mode), 32'd0);
    chk("rst_mid_math_a", 32'(math_a), 32'd0);
    chk("rst_mid_math_b", 32'(math_b), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // a fresh run after reset still works
    dist_q = '{1};
    mission(12'h010, 12'h020, 12'h030, 5'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
